// File: rtl/alu_arbitro.sv
// Two-requester round-robin front end sharing one 32-bit ALU.
// Operands are captured at grant; the result is held until acknowledged.

module alu (
  input  logic [31:0] ope1,
  input  logic [31:0] ope2,
  input  logic [2:0]  aluop,
  output logic [31:0] y,
  output logic        err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (aluop)
      3'b000:  y = ope1 & ope2;
      3'b001:  y = ope1 | ope2;
      3'b010:  y = ope1 + ope2;
      3'b110:  y = ope1 - ope2;
      3'b111:  y = {31'd0, ope1 > ope2};
      default: err = 1'b1;
    endcase
  end

endmodule

module alu_arbitro (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req0,
  input  logic [31:0] Ope1_0,
  input  logic [31:0] Ope2_0,
  input  logic [2:0]  AluOp0,
  output logic        Gnt0,
  input  logic        Req1,
  input  logic [31:0] Ope1_1,
  input  logic [31:0] Ope2_1,
  input  logic [2:0]  AluOp1,
  output logic        Gnt1,
  output logic [31:0] Resultado,
  output logic        Valido,
  output logic        Id,
  output logic        Error,
  input  logic        Ack,
  output logic        Ocupado
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [2:0]  op_q, op_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [31:0] res_q, res_d;
  logic        err_q, err_d;
  logic        val_q, val_d;

  logic [31:0] alu_y;
  logic        alu_err;
  logic        win;
  logic        any;

  alu u_alu (
    .ope1  (op1_q),
    .ope2  (op2_q),
    .aluop (op_q),
    .y     (alu_y),
    .err   (alu_err)
  );

  // Under contention the requester not granted last wins.
  always_comb begin
    win = 1'b0;
    any = Req0 | Req1;
    unique case (1'b1)
      (Req0 & Req1):  win = ~last_q;
      (Req1 & ~Req0): win = 1'b1;
      default:        win = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    op_d    = op_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    last_d  = last_q;
    id_d    = id_q;
    res_d   = res_q;
    err_d   = err_q;
    val_d   = val_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = EXEC;
          op1_d   = win ? Ope1_1 : Ope1_0;
          op2_d   = win ? Ope2_1 : Ope2_0;
          op_d    = win ? AluOp1 : AluOp0;
          gnt0_d  = ~win;
          gnt1_d  = win;
          id_d    = win;
          last_d  = win;
        end
      end
      EXEC: begin
        res_d   = alu_err ? 32'd0 : alu_y;
        err_d   = alu_err;
        val_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (Ack) begin
          val_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      op_q    <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      op_q    <= op_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      last_q  <= last_d;
      id_q    <= id_d;
      res_q   <= res_d;
      err_q   <= err_d;
      val_q   <= val_d;
    end
  end

  assign Gnt0      = gnt0_q;
  assign Gnt1      = gnt1_q;
  assign Resultado = res_q;
  assign Valido    = val_q;
  assign Id        = id_q;
  assign Error     = err_q;
  assign Ocupado   = (state_q != IDLE);

endmodule
